// File: rtl/user_uart_pkg.sv
// Shared definitions for the user-project UART transmitter: FSM encoding and frame constants.
package user_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/user_uart_tx_fifo.sv
// Synchronous byte FIFO: register array, read/write pointers with an extra wrap bit, explicit level count.
module user_uart_tx_fifo
  import user_uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_BITS-1:0]         push_data,
  input  logic                         pop,
  output logic [DATA_BITS-1:0]         pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Push is gated by full, pop by empty; a pop on an empty FIFO can never meet a push.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);

endmodule

// File: rtl/user_uart_tx.sv
// UART transmitter with byte FIFO, 8N1 frames at a programmable bit period in wb_clk_i cycles.
// Define USER_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module user_uart_tx
  import user_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [DIV_W-1:0]              clkdiv,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_eff;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sreg_q, sreg_d;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full, fifo_empty;
  logic                 pop, bit_end;
  logic                 tx_q, tx_d;
`ifdef USER_UART_TX_PARITY_EN
  logic                 par_q;
`endif

  user_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign div_eff = (clkdiv == '0) ? DIV_W'(1) : clkdiv;
  assign bit_end = (cnt_q == '0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      tx_q    <= STOP_BIT;
      div_q   <= DIV_W'(1);
      cnt_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
`ifdef USER_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      // The bit period is sampled once per frame so clkdiv changes never tear a frame.
      if (pop) div_q <= div_eff;
`ifdef USER_UART_TX_PARITY_EN
      if (pop) par_q <= ^fifo_data;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    if (state_q != ST_IDLE) cnt_d = bit_end ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          sreg_d = sreg_q >> 1;
          bit_d  = bit_q + 3'd1;
          // The 3-bit counter wrapping back to zero marks the last data bit.
          if (bit_d == 3'd0) begin
`ifdef USER_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef USER_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      sreg_d = fifo_data;
      cnt_d  = div_eff - DIV_W'(1);
      bit_d  = 3'd0;
    end
  end

  // Line level is derived from the next state so the registered output lines up with the state.
  always_comb begin
    tx_d = STOP_BIT;
    case (state_d)
      ST_START:  tx_d = START_BIT;
      ST_DATA:   tx_d = sreg_d[0];
`ifdef USER_UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_q;
`endif
      default:   tx_d = STOP_BIT;
    endcase
  end

  assign uart_tx  = tx_q;
  assign busy     = (state_q != ST_IDLE) | ~fifo_empty;
  assign tx_ready = ~fifo_full;

endmodule

// File: tb/tb_user_uart_tx.sv
// Self-checking bench for user_uart_tx: table of single frames, back-to-back streams, FIFO fill, reset mid-frame, random bursts.
module tb_user_uart_tx;

`ifdef USER_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] clkdiv;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        uart_tx;
  logic        busy;
  logic [3:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  user_uart_tx #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .clkdiv     (clkdiv),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference line level for bit slot i of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
`ifdef USER_UART_TX_PARITY_EN
    if (i == 9) return ($countones(d) % 2) == 1;
`endif
    return 1'b1;
  endfunction

  function automatic int eff_div(input int div);
    return (div == 0) ? 1 : div;
  endfunction

  task automatic push_burst(input logic [7:0] q[$]);
    int  i = 0;
    int  guard = 0;
    logic rdy;
    while (i < q.size() && guard < 20000) begin
      tx_data  = q[i];
      tx_valid = 1'b1;
      rdy      = tx_ready;
      @(negedge clk);
      if (rdy) i++;
      guard++;
    end
    tx_valid = 1'b0;
    if (i != q.size()) chk("push_accept", i, q.size());
  endtask

  // Waits for the first start bit, then compares every cycle of every frame against the model.
  task automatic stream_check(input logic [7:0] q[$], input int div);
    int d = eff_div(div);
    int t = 0;
    int bad;
    logic [7:0] rx;
    while (uart_tx !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("stream_start", uart_tx, 1'b0);
    foreach (q[f]) begin
      bad = 0;
      rx  = 8'h00;
      for (int b = 0; b < FB; b++) begin
        for (int c = 0; c < d; c++) begin
          if (uart_tx !== frame_bit(q[f], b)) bad++;
          if (busy !== 1'b1) bad++;
          if (c == d / 2 && b >= 1 && b <= 8) rx[b-1] = uart_tx;
          @(negedge clk);
        end
      end
      chk("stream_line_errs", bad, 0);
      chk("stream_rx_byte", rx, q[f]);
    end
    chk("stream_busy_end", busy, 1'b0);
    chk("stream_idle_line", uart_tx, 1'b1);
  endtask

  typedef struct {
    int         div;
    logic [7:0] data;
    int         len8n1;
    logic       par;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [7:0] q[$];
    logic       samp[$];
    logic [7:0] rx;
    int         d, guard, bad, n;

    tbl = '{
      '{4, 8'hA5, 40, 1'b0},
      '{0, 8'h3C, 10, 1'b0},
      '{4, 8'h01, 40, 1'b1},
      '{3, 8'hFF, 30, 1'b0},
      '{2, 8'h81, 20, 1'b0},
      '{7, 8'h07, 70, 1'b1},
      '{1, 8'h00, 10, 1'b0}
    };

    rst = 1'b1; clkdiv = 16'd4; tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_uart_tx", uart_tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_tx_ready", tx_ready, 1'b1);
    chk("reset_level", fifo_level, 4'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frames from the table: latency, exact length, decoded byte.
    for (int k = 0; k < 7; k++) begin
      clkdiv = tbl[k].div[15:0];
      d = eff_div(tbl[k].div);
      q = '{tbl[k].data};
      push_burst(q);
      chk("lat_cycle_n1", uart_tx, 1'b1);
      chk("lat_busy", busy, 1'b1);
      @(negedge clk);
      samp = {};
      guard = 0;
      while (busy === 1'b1 && guard < 20000) begin
        samp.push_back(uart_tx);
        @(negedge clk);
        guard++;
      end
      chk("frame_len", samp.size(), tbl[k].len8n1 * FB / 10);
      chk("start_at_n2", samp[0], 1'b0);
      rx = 8'h00;
      bad = 0;
      for (int b = 0; b < 8; b++) rx[b] = samp[(1 + b) * d + d / 2];
      for (int t = 0; t < samp.size() && t < FB * d; t++)
        if (samp[t] !== frame_bit(tbl[k].data, t / d)) bad++;
      chk("frame_byte", rx, tbl[k].data);
      chk("frame_line_errs", bad, 0);
`ifdef USER_UART_TX_PARITY_EN
      chk("frame_parity", samp[9 * d + d / 2], tbl[k].par);
`endif
      chk("frame_stop", samp[(FB - 1) * d + d / 2], 1'b1);
      chk("frame_idle_after", uart_tx, 1'b1);
      @(negedge clk);
    end

    // Back-to-back frames with no idle gap.
    clkdiv = 16'd2;
    q = '{8'h00, 8'hFF, 8'h55};
    fork
      push_burst(q);
      stream_check(q, 2);
    join
    repeat (2) @(negedge clk);

    // FIFO fill: the first byte leaves immediately, so nine pushes end with level 8 and ready low.
    clkdiv = 16'd20;
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    fork
      begin
        push_burst(q);
        chk("fill_level", fifo_level, 4'd8);
        chk("fill_ready", tx_ready, 1'b0);
        @(negedge clk);
        chk("fill_push_ignored_level", fifo_level, 4'd8);
      end
      stream_check(q, 20);
    join
    repeat (2) @(negedge clk);

    // Reset during data bit 3 with four bytes still queued.
    clkdiv = 16'd8;
    q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fork
      push_burst(q);
      begin
        guard = 0;
        while (uart_tx !== 1'b0 && guard < 1000) begin
          @(negedge clk);
          guard++;
        end
        repeat (8 + 3 * 8 + 2) @(negedge clk);
      end
    join
    chk("pre_reset_line", uart_tx, 1'b0);
    chk("pre_reset_level", fifo_level, 4'd4);
    rst = 1'b1;
    #1;
    chk("rst_line_high", uart_tx, 1'b1);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", tx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("post_reset_quiet", bad, 0);

    // Random bursts against the frame model.
    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(0, 5);
      clkdiv = d[15:0];
      n = $urandom_range(1, 5);
      q = {};
      for (int j = 0; j < n; j++) q.push_back(8'($urandom));
      fork
        push_burst(q);
        stream_check(q, d);
      join
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
